// File: rtl/fft_core.sv
// 2-point radix-2 FFT butterfly on binary32 samples, AXI-Stream in/out, compute on start pulse.
// Latency: first output beat 3 cycles after the start cycle (two passes through one shared float adder).
// Backpressure: input ready only while loading; output beats hold data/last steady while m00_axis_tready=0.
module fft_core #(
  parameter int SIZE       = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  output logic                      s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                      s00_axis_tlast,
  input  logic                      s00_axis_tvalid,
  output logic                      m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready,
  input  logic                      start
);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_LOADED = 2'd1;
  localparam logic [1:0] S_CALC   = 2'd2;
  localparam logic [1:0] S_SEND   = 2'd3;
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] x [SIZE];
  logic                  phase;     // 0: difference pass, 1: sum pass
  logic [DATA_WIDTH-1:0] sum_r;
  logic [DATA_WIDTH-1:0] add_b;
  logic [DATA_WIDTH-1:0] add_res;

  // binary32 add, round-to-nearest-even, subnormals flushed to signed zero
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic              sa, sb, sl, ss;
    logic [7:0]        ea, eb, el, es, d;
    logic [22:0]       fa, fb;
    logic [26:0]       ml, ms, msh;
    logic [27:0]       acc;
    logic signed [9:0] e;
    logic [24:0]       rnd;
    logic              rup;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    sl = 1'b0; ss = 1'b0; el = '0; es = '0; ml = '0; ms = '0; msh = '0;
    d = '0; acc = '0; e = '0; rnd = '0; rup = 1'b0;
    fp_add = 32'h0;
    if ((ea == 8'hFF && fa != 23'd0) || (eb == 8'hFF && fb != 23'd0)) begin
      fp_add = QNAN;
    end else if (ea == 8'hFF && eb == 8'hFF) begin
      fp_add = (sa != sb) ? QNAN : a;
    end else if (ea == 8'hFF) begin
      fp_add = a;
    end else if (eb == 8'hFF) begin
      fp_add = b;
    end else if (ea == 8'd0 && eb == 8'd0) begin
      fp_add = {sa & sb, 31'd0};
    end else if (ea == 8'd0) begin
      fp_add = b;
    end else if (eb == 8'd0) begin
      fp_add = a;
    end else begin
      // larger magnitude first; its sign is the result sign unless it cancels
      if ({ea, fa} >= {eb, fb}) begin
        sl = sa; el = ea; ml = {1'b1, fa, 3'b000};
        ss = sb; es = eb; ms = {1'b1, fb, 3'b000};
      end else begin
        sl = sb; el = eb; ml = {1'b1, fb, 3'b000};
        ss = sa; es = ea; ms = {1'b1, fa, 3'b000};
      end
      d = el - es;
      if (d >= 8'd27) begin
        msh = 27'd1;
      end else begin
        msh = ms >> d;
        if ((ms & ((27'd1 << d) - 27'd1)) != 27'd0) msh[0] = 1'b1;
      end
      e = {2'b00, el};
      if (sl == ss) begin
        acc = {1'b0, ml} + {1'b0, msh};
        if (acc[27]) begin
          acc = {1'b0, acc[27:1]} | {27'd0, acc[0]};
          e = e + 10'sd1;
        end
      end else begin
        acc = {1'b0, ml} - {1'b0, msh};
      end
      if (acc != 28'd0) begin
        for (int i = 0; i < 27; i++) begin
          if (!acc[26]) begin
            acc = acc << 1;
            e = e - 10'sd1;
          end
        end
        rup = acc[2] & (acc[1] | acc[0] | acc[3]);
        rnd = {1'b0, acc[26:3]} + {24'd0, rup};
        if (rnd[24]) begin
          rnd = rnd >> 1;
          e = e + 10'sd1;
        end
        if (e <= 10'sd0)        fp_add = {sl, 31'd0};
        else if (e >= 10'sd255) fp_add = {sl, 8'hFF, 23'd0};
        else                    fp_add = {sl, e[7:0], rnd[22:0]};
      end
    end
  endfunction

  assign add_b   = phase ? x[1] : {~x[1][DATA_WIDTH-1], x[1][DATA_WIDTH-2:0]};
  assign add_res = fp_add(x[0], add_b);

  assign s00_axis_tready = (state == S_LOAD);
  assign m00_axis_tstrb  = {(DATA_WIDTH/8){1'b1}};

  // frame FSM: load samples, wait for start, two adder passes, stream out X1 then X0
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state           <= S_LOAD;
      cnt             <= '0;
      for (int i = 0; i < SIZE; i++) x[i] <= '0;
      phase           <= 1'b0;
      sum_r           <= '0;
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (s00_axis_tvalid) begin
            x[cnt] <= s00_axis_tdata;
            cnt    <= cnt + 1'b1;
            if (s00_axis_tlast || cnt == CW'(SIZE - 1)) state <= S_LOADED;
          end
        end
        S_LOADED: begin
          if (start) begin
            phase <= 1'b0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (!phase) begin
            m00_axis_tdata <= add_res;
            phase          <= 1'b1;
          end else begin
            sum_r           <= add_res;
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= 1'b0;
            state           <= S_SEND;
          end
        end
        S_SEND: begin
          if (m00_axis_tready) begin
            if (!m00_axis_tlast) begin
              m00_axis_tdata <= sum_r;
              m00_axis_tlast <= 1'b1;
            end else begin
              m00_axis_tvalid <= 1'b0;
              m00_axis_tlast  <= 1'b0;
              cnt             <= '0;
              // unloaded slots of the next frame must read as zero
              for (int i = 0; i < SIZE; i++) x[i] <= '0;
              state           <= S_LOAD;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_core.sv
// Directed bench for fft_core: scoreboard of expected output beats, checked as they stream out.
// Covers reset values, arithmetic cases, special values, ignored starts, early tlast, stalls, reset mid-send.
module tb_fft_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tvalid;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;
  logic        m_tready;
  logic        start;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] sb [$];   // {tlast, tdata}

  always #5 clk = ~clk;

  fft_core dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axis_tready (s_tready),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tvalid (s_tvalid),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .start           (start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    while (!s_tready && t < 20) begin @(negedge clk); t++; end
    chk("in_ready", {31'd0, s_tready}, 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic pulse_start();
    int lat = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!m_tvalid && lat < 20) begin @(negedge clk); lat++; end
    chk("latency_le_8", {31'd0, (lat <= 8)}, 32'd1);
  endtask

  task automatic recv_beats(input int n, input int stall);
    logic [32:0] e;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!m_tvalid && t < 50) begin @(negedge clk); t++; end
      chk("out_valid", {31'd0, m_tvalid}, 32'd1);
      chk("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
      e = (sb.size() > 0) ? sb.pop_front() : 33'h0;
      chk("out_data", m_tdata, e[31:0]);
      chk("out_last", {31'd0, m_tlast}, {31'd0, e[32]});
      chk("out_strb", {28'd0, m_tstrb}, 32'hF);
      if (stall > 0 && k == 0) begin
        m_tready = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
          chk("stall_data", m_tdata, e[31:0]);
          chk("stall_last", {31'd0, m_tlast}, {31'd0, e[32]});
        end
        m_tready = 1'b1;
      end
      @(negedge clk);
    end
    chk("post_valid", {31'd0, m_tvalid}, 32'd0);
    chk("post_last", {31'd0, m_tlast}, 32'd0);
    chk("post_ready", {31'd0, s_tready}, 32'd1);
  endtask

  task automatic frame(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] x0, input logic [31:0] x1, input int stall);
    sb.push_back({1'b0, x1});
    sb.push_back({1'b1, x0});
    send_beat(a, 1'b0);
    send_beat(b, 1'b0);
    chk("loaded_ready", {31'd0, s_tready}, 32'd0);
    pulse_start();
    recv_beats(2, stall);
  endtask

  initial begin
    rst_n = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    m_tready = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready", {31'd0, s_tready}, 32'd1);
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    rst_n = 1'b1;

    // start while loading must be ignored
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_in_load_valid", {31'd0, m_tvalid}, 32'd0);
    chk("start_in_load_ready", {31'd0, s_tready}, 32'd1);

    frame(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0);
    frame(32'h4049_0FDB, 32'hC049_0FDB, 32'h0000_0000, 32'h40C9_0FDB, 0);
    frame(32'h42F6_E979, 32'h42DE_38D5, 32'h436A_9127, 32'h4145_8520, 0);
    frame(32'hC2F6_E979, 32'h42DE_38D5, 32'hC145_8520, 32'hC36A_9127, 0);
    frame(32'h42F6_E979, 32'hC2DE_38D5, 32'h4145_8520, 32'h436A_9127, 0);
    frame(32'hC2F6_E979, 32'hC2DE_38D5, 32'hC36A_9127, 32'hC145_8520, 5);
    // Inf + Inf = Inf, Inf - Inf = qNaN
    frame(32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 0);
    // overflow to +Inf, exact cancellation to +0
    frame(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h0000_0000, 0);

    // start coinciding with the last load beat is ignored
    sb.push_back({1'b0, 32'h0000_0000});
    sb.push_back({1'b1, 32'h4000_0000});
    send_beat(32'h3F80_0000, 1'b0);
    @(negedge clk);
    s_tdata = 32'h3F80_0000; s_tvalid = 1'b1; start = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0; start = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_start_valid", {31'd0, m_tvalid}, 32'd0);
    chk("late_start_ready", {31'd0, s_tready}, 32'd0);
    pulse_start();
    recv_beats(2, 0);

    // early tlast: second sample stays zero
    sb.push_back({1'b0, 32'h40A0_0000});
    sb.push_back({1'b1, 32'h40A0_0000});
    send_beat(32'h40A0_0000, 1'b1);
    chk("early_last_ready", {31'd0, s_tready}, 32'd0);
    pulse_start();
    recv_beats(2, 0);

    // reset in the middle of sending aborts the frame
    send_beat(32'h4120_0000, 1'b0);
    send_beat(32'h4100_0000, 1'b0);
    pulse_start();
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("midrst_tready", {31'd0, s_tready}, 32'd1);
    chk("midrst_tdata", m_tdata, 32'd0);
    chk("midrst_tlast", {31'd0, m_tlast}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    frame(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'hBF80_0000, 0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
